// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS-subset datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    // Instruction fields and status coming back from the datapath
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             mem_ready;

    // Datapath strobes and selects
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             reg_write;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             inv_branch_cond;
    logic             jump;
    logic             link;
    logic [1:0]       reg_dest;
    logic [1:0]       mem_to_reg;
    logic [2:0]       alu_op;

    // Retire / status
    logic             instr_done;
    logic             trap;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  op, funct, alu_zero, mem_ready,
        output iord, ir_write, pc_write, pc_write_cond, reg_write, alu_src,
               mem_read, mem_write, branch, inv_branch_cond, jump, link,
               reg_dest, mem_to_reg, alu_op, instr_done, trap, instr_count
    );

    modport slave (
        output op, funct, alu_zero, mem_ready,
        input  iord, ir_write, pc_write, pc_write_cond, reg_write, alu_src,
               mem_read, mem_write, branch, inv_branch_cond, jump, link,
               reg_dest, mem_to_reg, alu_op, instr_done, trap, instr_count
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for a MIPS-subset datapath sharing one memory
// port between instruction fetch and data access. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, counts retirements
// and parks in TRAP on an illegal instruction until reset.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;

    // Mux select encodings
    localparam logic       SRC_RT   = 1'b0;
    localparam logic       SRC_IMM  = 1'b1;
    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_LINK = 2'd2;
    localparam logic [1:0] WBS_ALU  = 2'd0;
    localparam logic [1:0] WBS_MEM  = 2'd1;
    localparam logic [1:0] WBS_PC   = 2'd2;

    state_t           r_state;
    logic [5:0]       r_op;
    logic [5:0]       r_funct;
    logic             r_trap;
    logic [CNT_W-1:0] r_count;

    logic       w_iord, w_ir_write, w_pc_write, w_pc_write_cond, w_reg_write;
    logic       w_alu_src, w_mem_read, w_mem_write, w_branch, w_inv_branch_cond;
    logic       w_jump, w_link, w_retire;
    logic [1:0] w_reg_dest, w_mem_to_reg;
    logic [2:0] w_alu_op;

    function automatic logic f_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_SLT, F_AND, F_OR, F_NOR, F_XOR, F_JR: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] f_rtype_alu(input logic [5:0] funct);
        logic [2:0] aop;
        case (funct)
            F_SUB:   aop = ALU_SUB;
            F_SLT:   aop = ALU_SLT;
            F_AND:   aop = ALU_AND;
            F_OR:    aop = ALU_OR;
            F_NOR:   aop = ALU_NOR;
            F_XOR:   aop = ALU_XOR;
            default: aop = ALU_ADD;
        endcase
        return aop;
    endfunction

    // Decode strobes from the current state and the latched instruction fields
    always_comb begin
        w_iord            = 1'b0;
        w_ir_write        = 1'b0;
        w_pc_write        = 1'b0;
        w_pc_write_cond   = 1'b0;
        w_reg_write       = 1'b0;
        w_alu_src         = SRC_RT;
        w_mem_read        = 1'b0;
        w_mem_write       = 1'b0;
        w_branch          = 1'b0;
        w_inv_branch_cond = 1'b0;
        w_jump            = 1'b0;
        w_link            = 1'b0;
        w_reg_dest        = DST_RT;
        w_mem_to_reg      = WBS_ALU;
        w_alu_op          = ALU_ADD;
        w_retire          = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Address from PC; the ALU default (ADD) produces PC+4
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                case (r_op)
                    OP_RTYPE: begin
                        if (r_funct == F_JR) begin
                            w_jump     = 1'b1;
                            w_pc_write = 1'b1;
                            w_retire   = 1'b1;
                        end else begin
                            w_alu_op = f_rtype_alu(r_funct);
                        end
                    end
                    OP_ADDI: w_alu_src = SRC_IMM;
                    OP_XORI: begin
                        w_alu_src = SRC_IMM;
                        w_alu_op  = ALU_XOR;
                    end
                    OP_LW, OP_SW: w_alu_src = SRC_IMM;
                    OP_BEQ, OP_BNE: begin
                        w_alu_op          = ALU_SUB;
                        w_branch          = 1'b1;
                        w_pc_write_cond   = 1'b1;
                        w_inv_branch_cond = (r_op == OP_BNE);
                        w_retire          = 1'b1;
                    end
                    OP_J: begin
                        w_jump     = 1'b1;
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                    end
                    OP_JAL: begin
                        w_jump       = 1'b1;
                        w_link       = 1'b1;
                        w_pc_write   = 1'b1;
                        w_reg_write  = 1'b1;
                        w_reg_dest   = DST_LINK;
                        w_mem_to_reg = WBS_PC;
                        w_retire     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Strobes held steady for the whole stall
                w_iord = 1'b1;
                if (r_op == OP_LW) begin
                    w_mem_read = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                    w_retire    = bus.mem_ready;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                if (r_op == OP_LW) begin
                    w_mem_to_reg = WBS_MEM;
                end else if (r_op == OP_RTYPE) begin
                    w_reg_dest = DST_RD;
                end
            end
            default: ;
        endcase
    end

    // State sequencing, instruction-field latch, sticky trap and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_funct <= '0;
            r_trap  <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_retire) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op    <= bus.op;
                    r_funct <= bus.funct;
                    if (f_legal(bus.op, bus.funct)) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        OP_LW, OP_SW:     r_state <= S_MEM;
                        OP_ADDI, OP_XORI: r_state <= S_WB;
                        OP_RTYPE:         r_state <= (r_funct == F_JR) ? S_FETCH : S_WB;
                        default:          r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        r_state <= (r_op == OP_LW) ? S_WB : S_FETCH;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Everything is forced low while reset is held, so an aborted access
    // never leaves a strobe asserted
    assign bus.iord            = rst_n & w_iord;
    assign bus.ir_write        = rst_n & w_ir_write;
    assign bus.pc_write        = rst_n & w_pc_write;
    assign bus.pc_write_cond   = rst_n & w_pc_write_cond;
    assign bus.reg_write       = rst_n & w_reg_write;
    assign bus.alu_src         = rst_n & w_alu_src;
    assign bus.mem_read        = rst_n & w_mem_read;
    assign bus.mem_write       = rst_n & w_mem_write;
    assign bus.branch          = rst_n & w_branch;
    assign bus.inv_branch_cond = rst_n & w_inv_branch_cond;
    assign bus.jump            = rst_n & w_jump;
    assign bus.link            = rst_n & w_link;
    assign bus.reg_dest        = rst_n ? w_reg_dest   : 2'd0;
    assign bus.mem_to_reg      = rst_n ? w_mem_to_reg : 2'd0;
    assign bus.alu_op          = rst_n ? w_alu_op     : 3'd0;
    assign bus.instr_done      = rst_n & w_retire;
    assign bus.trap            = rst_n & r_trap;
    assign bus.instr_count     = r_count;

endmodule
